// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath width, default PC step, fetch FSM states.
package proc_pkg;
  localparam int XLEN = 16;
  localparam logic [XLEN-1:0] PC_STEP_DEF = 16'd16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/adder_16.sv
// 16-bit ripple adder with carry in/out; wraps modulo 2^16.
module adder_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: requests one word at PC, parks it in the IR until decode
// accepts it, and handles redirects, including one that lands mid-request.
module instr_fetch
  import proc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 16'h0000,
  parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            ir_valid,
  input  logic            ir_ready,
  output logic [XLEN-1:0] ir_instr,
  output logic [XLEN-1:0] ir_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_inc;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            irv_q, irv_d;
  logic [XLEN-1:0] iri_q, iri_d;
  logic [XLEN-1:0] irp_q, irp_d;

  adder_16 u_pc_add (
    .a   (pc_q),
    .b   (PC_STEP),
    .cin (1'b0),
    .sum (pc_inc),
    .cout()
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    irv_d   = irv_q;
    iri_d   = iri_q;
    irp_d   = irp_q;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) pc_d = redirect_pc;
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = pc_d;
      end
      REQ: begin
        if (redirect_valid && imem_ack) begin
          pc_d   = redirect_pc;
          addr_d = redirect_pc;
        end else if (redirect_valid) begin
          // the outstanding read must still complete at its old address
          pc_d    = redirect_pc;
          state_d = FLUSH;
        end else if (imem_ack) begin
          iri_d   = imem_rdata;
          irp_d   = addr_q;
          irv_d   = 1'b1;
          pc_d    = pc_inc;
          req_d   = 1'b0;
          state_d = HOLD;
        end
      end
      FLUSH: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (imem_ack) begin
          state_d = REQ;
          addr_d  = pc_d;
        end
      end
      HOLD: begin
        if (redirect_valid || ir_ready) begin
          if (redirect_valid) pc_d = redirect_pc;
          irv_d   = 1'b0;
          req_d   = 1'b1;
          addr_d  = pc_d;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      irv_q   <= 1'b0;
      iri_q   <= '0;
      irp_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      irv_q   <= irv_d;
      iri_q   <= iri_d;
      irp_q   <= irp_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ir_valid  = irv_q;
  assign ir_instr  = iri_q;
  assign ir_pc     = irp_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed-vector bench for instr_fetch; a second instance covers PC wrap at 16'hFFF0.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, ir_valid;
  logic [15:0] imem_addr, ir_instr, ir_pc;
  logic        imem_ack, ir_ready, redirect_valid;
  logic [15:0] imem_rdata, redirect_pc;

  logic        w_req, w_valid, w_ack;
  logic [15:0] w_addr, w_instr, w_pc;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  instr_fetch u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_instr(ir_instr), .ir_pc(ir_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  instr_fetch #(.RESET_PC(16'hFFF0)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(16'h1111),
    .ir_valid(w_valid), .ir_ready(1'b1),
    .ir_instr(w_instr), .ir_pc(w_pc),
    .redirect_valid(1'b0), .redirect_pc(16'h0000)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ir(input string tag, input logic v, input logic [15:0] ins, input logic [15:0] pc);
    chk({tag, ".valid"}, {15'd0, ir_valid}, {15'd0, v});
    chk({tag, ".instr"}, ir_instr, ins);
    chk({tag, ".pc"}, ir_pc, pc);
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [15:0] a);
    chk({tag, ".req"}, {15'd0, imem_req}, {15'd0, r});
    chk({tag, ".addr"}, imem_addr, a);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; ir_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; w_ack = 1'b0;
    tick(); tick();
    chk_req("rst", 1'b0, 16'h0000);
    chk_ir("rst", 1'b0, 16'h0000, 16'h0000);
    chk("rst.wrap_addr", w_addr, 16'hFFF0);

    // release just after an edge: that edge leaves the FSM in IDLE, the next enters REQ
    rst = 1'b0;
    chk_req("idle", 1'b0, 16'h0000);
    tick();
    chk_req("req0", 1'b1, 16'h0000);
    chk("wrap.req_addr", w_addr, 16'hFFF0);

    // one wait cycle, address must hold; wrap instance gets its ack now
    ir_ready = 1'b1; w_ack = 1'b1;
    tick();
    chk_req("req0.wait", 1'b1, 16'h0000);
    chk("wrap.ir_pc", w_pc, 16'hFFF0);
    w_ack = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'hA5A5;
    tick();
    chk_ir("f0", 1'b1, 16'hA5A5, 16'h0000);
    chk("f0.req", {15'd0, imem_req}, 16'd0);
    chk("wrap.next_addr", w_addr, 16'h0000);
    imem_ack = 1'b0;
    tick();
    chk_req("f1", 1'b1, 16'h0010);
    chk("f1.valid", {15'd0, ir_valid}, 16'd0);

    // decode stalls 5 cycles; a stray ack in HOLD must be ignored
    ir_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h1234;
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin imem_ack = 1'b1; imem_rdata = 16'hBAD0; end
      else imem_ack = 1'b0;
      tick();
      chk_ir("stall", 1'b1, 16'h1234, 16'h0010);
      chk("stall.req", {15'd0, imem_req}, 16'd0);
    end
    imem_ack = 1'b0; ir_ready = 1'b1;
    tick();
    chk_req("f2", 1'b1, 16'h0020);
    ir_ready = 1'b0;

    // redirect before ack -> FLUSH at old address, response dropped
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    chk_req("flush", 1'b1, 16'h0020);
    tick();
    chk_req("flush.wait", 1'b1, 16'h0020);
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    tick();
    chk_req("redir", 1'b1, 16'h0100);
    chk("redir.valid", {15'd0, ir_valid}, 16'd0);
    imem_rdata = 16'hBEEF;
    tick();
    chk_ir("redir.f", 1'b1, 16'hBEEF, 16'h0100);
    imem_ack = 1'b0; ir_ready = 1'b1;
    tick();
    chk_req("redir.next", 1'b1, 16'h0110);
    ir_ready = 1'b0;

    // redirect coincident with ack: data dropped, refetch at target
    imem_ack = 1'b1; imem_rdata = 16'h5555;
    redirect_valid = 1'b1; redirect_pc = 16'h0200;
    tick();
    redirect_valid = 1'b0; imem_ack = 1'b0;
    chk("rack.valid", {15'd0, ir_valid}, 16'd0);
    chk_req("rack", 1'b1, 16'h0200);
    imem_ack = 1'b1; imem_rdata = 16'h6666;
    tick();
    imem_ack = 1'b0;
    chk_ir("rack.f", 1'b1, 16'h6666, 16'h0200);

    // redirect in HOLD with ready
    redirect_valid = 1'b1; redirect_pc = 16'h0300; ir_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; ir_ready = 1'b0;
    chk_req("hredir", 1'b1, 16'h0300);
    chk("hredir.valid", {15'd0, ir_valid}, 16'd0);

    // async reset mid-request, late ack ignored
    tick();
    #2 rst = 1'b1;
    #1;
    chk_req("arst", 1'b0, 16'h0000);
    chk_ir("arst", 1'b0, 16'h0000, 16'h0000);
    imem_ack = 1'b1; imem_rdata = 16'hCCCC;
    tick();
    rst = 1'b0;
    tick();
    chk_req("arst.restart", 1'b1, 16'h0000);
    chk("arst.valid", {15'd0, ir_valid}, 16'd0);
    imem_rdata = 16'h7777;
    tick();
    imem_ack = 1'b0;
    chk_ir("arst.f", 1'b1, 16'h7777, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
